// File: rtl/isa_pkg.sv
// Shared instruction-set definitions for the fetch sequencer and its neighbours.
//   - instruction group constants and the group mask (bits 23:19)
//   - flow-control operation codes (bits 15:12 of a flow-group word)
//   - fetch FSM state encoding
//   - is_flow(): identifies a flow-control group word
package isa_pkg;

    // Instruction groups, one-hot in bits 23:19.
    // Only the flow group is decoded by the fetch sequencer.
    localparam logic [23:0] GRP_FLOW = 24'h800000;
    localparam logic [23:0] GRP_G1   = 24'h400000;
    localparam logic [23:0] GRP_G2   = 24'h200000;
    localparam logic [23:0] GRP_G3   = 24'h100000;
    localparam logic [23:0] GRP_G4   = 24'h080000;
    localparam logic [23:0] GRP_MASK = 24'hF80000;

    // Flow-control operation codes. Codes 6/7 (MOM) and anything above 7 fall
    // through as ordinary instructions.
    localparam logic [3:0] OP_JMP = 4'd0;
    localparam logic [3:0] OP_JZE = 4'd1;
    localparam logic [3:0] OP_JNE = 4'd2;
    localparam logic [3:0] OP_JCY = 4'd3;
    localparam logic [3:0] OP_RET = 4'd4;
    localparam logic [3:0] OP_BSR = 4'd5;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

    function automatic logic is_flow(input logic [23:0] word);
        return (word & GRP_MASK) == GRP_FLOW;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for subroutine calls.
//   clk, rst_n : clock, synchronous active-low reset (empties the stack)
//   push, din  : store din on top (ignored when full)
//   pop        : discard top entry (ignored when empty)
//   dout       : current top entry (meaningless when empty)
//   full/empty : occupancy flags
// push and pop are never asserted together by the fetch sequencer.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    // sp counts 0..DEPTH, so it needs one bit more than the entry index.
    logic [SP_W-1:0]  sp;
    logic [W-1:0]     mem [DEPTH];
    logic [IDX_W-1:0] top_idx;

    assign top_idx = IDX_W'(sp - 1'b1);
    assign full    = (sp == SP_W'(DEPTH));
    assign empty   = (sp == '0);
    assign dout    = mem[top_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= din;
            sp                 <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the program counter, reads instructions
// from synchronous program memory, presents them on IR to the decoder and
// resolves flow control (JMP/JZE/JNE/JCY/BSR/RET) with a return stack.
//   clk, rst_n       : clock, synchronous active-low reset
//   run              : fetch enable, sampled only in FETCH
//   pm_addr, pm_rd   : program memory address / read strobe
//   pm_data          : program memory data, valid the cycle after pm_rd
//   z_flag, cy_flag  : datapath flags, sampled in LOAD
//   IR, ir_valid     : current instruction and its qualifier (EXEC)
//   pc               : program counter
//   stack_err        : sticky return-stack overflow/underflow
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | idle / issue read of pm[pc] when run=1
// ST_LOAD  | pm_data valid: load IR, resolve next pc, push/pop stack
// ST_EXEC  | IR live for EXEC_CYCLES cycles (down-counter to zero)
module instr_fetch_seq
    import isa_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int IR_W        = 24,
    parameter int STACK_DEPTH = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [PC_W-1:0] pm_addr,
    output logic            pm_rd,
    input  logic [IR_W-1:0] pm_data,
    input  logic            z_flag,
    input  logic            cy_flag,
    output logic [IR_W-1:0] IR,
    output logic            ir_valid,
    output logic [PC_W-1:0] pc,
    output logic            stack_err
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    fetch_state_t     state;
    logic [CNT_W-1:0] exec_cnt;

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  next_pc;
    logic [PC_W-1:0]  tgt;
    logic [3:0]       op;
    logic             st_push;
    logic             st_pop;
    logic             err_set;
    logic [PC_W-1:0]  st_dout;
    logic             st_full;
    logic             st_empty;

    // The read must be issued in the same cycle run is seen in FETCH so that
    // the data lands in LOAD; a registered strobe would add a cycle.
    assign pm_addr = pc;
    assign pm_rd   = (state == ST_FETCH) && run;

    assign pc_inc  = pc + 1'b1;
    assign tgt     = pm_data[PC_W-1:0];
    assign op      = pm_data[15:12];

    always_comb begin
        next_pc = pc_inc;
        st_push = 1'b0;
        st_pop  = 1'b0;
        err_set = 1'b0;
        if (state == ST_LOAD && is_flow(pm_data)) begin
            case (op)
                OP_JMP: next_pc = tgt;
                OP_JZE: if (z_flag)  next_pc = tgt;
                OP_JNE: if (!z_flag) next_pc = tgt;
                OP_JCY: if (cy_flag) next_pc = tgt;
                OP_RET: begin
                    if (st_empty) begin
                        err_set = 1'b1;
                    end else begin
                        st_pop  = 1'b1;
                        next_pc = st_dout;
                    end
                end
                OP_BSR: begin
                    next_pc = tgt;
                    if (st_full) err_set = 1'b1;
                    else         st_push = 1'b1;
                end
                default: next_pc = pc_inc;
            endcase
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (st_push),
        .pop   (st_pop),
        .din   (pc_inc),
        .dout  (st_dout),
        .full  (st_full),
        .empty (st_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= '0;
            IR        <= '0;
            ir_valid  <= 1'b0;
            exec_cnt  <= '0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (run) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    IR       <= pm_data;
                    pc       <= next_pc;
                    exec_cnt <= CNT_W'(EXEC_CYCLES - 1);
                    ir_valid <= 1'b1;
                    state    <= ST_EXEC;
                    if (err_set) stack_err <= 1'b1;
                end
                ST_EXEC: begin
                    if (exec_cnt == '0) begin
                        ir_valid <= 1'b0;
                        state    <= ST_FETCH;
                    end else begin
                        exec_cnt <= exec_cnt - 1'b1;
                    end
                end
                default: begin
                    ir_valid <= 1'b0;
                    state    <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq with a synchronous program memory model.
module tb_instr_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [11:0] pm_addr;
    logic        pm_rd;
    logic [23:0] pm_data;
    logic        z_flag;
    logic        cy_flag;
    logic [23:0] IR;
    logic        ir_valid;
    logic [11:0] pc;
    logic        stack_err;

    logic [23:0] pm [4096];
    int n_vec = 0;
    int n_err = 0;

    instr_fetch_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .pm_addr   (pm_addr),
        .pm_rd     (pm_rd),
        .pm_data   (pm_data),
        .z_flag    (z_flag),
        .cy_flag   (cy_flag),
        .IR        (IR),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (pm_rd) pm_data <= pm[pm_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Ends on a negedge with the block in FETCH, run low.
    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on a FETCH negedge with run=1; returns on the next FETCH negedge.
    task automatic fetch_instr(input string tag, input logic [11:0] exp_addr,
                               input logic [23:0] exp_ir, input logic [11:0] exp_pc);
        #1;
        chk({tag, ".pm_rd"}, pm_rd, 1'b1);
        chk({tag, ".pm_addr"}, pm_addr, exp_addr);
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".IR"}, IR, exp_ir);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".ir_valid1"}, ir_valid, 1'b1);
        @(negedge clk);
        chk({tag, ".ir_valid2"}, ir_valid, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) pm[i] = 24'h000000;
        pm_data = '0;
        z_flag  = 1'b0;
        cy_flag = 1'b0;
        @(negedge clk);
        do_reset();

        // reset state
        #1;
        chk("rst.pc", pc, 12'h000);
        chk("rst.IR", IR, 24'h000000);
        chk("rst.ir_valid", ir_valid, 1'b0);
        chk("rst.pm_rd", pm_rd, 1'b0);
        chk("rst.pm_addr", pm_addr, 12'h000);
        chk("rst.stack_err", stack_err, 1'b0);
        chk("rst.sp", dut.u_stack.sp, 4'd0);

        // sequential non-flow words
        pm[0] = 24'h123456; pm[1] = 24'h000001; pm[2] = 24'h3ABCDE; pm[3] = 24'h7FFFFF;
        @(negedge clk);
        run = 1'b1;
        fetch_instr("seq0", 12'h000, 24'h123456, 12'h001);
        fetch_instr("seq1", 12'h001, 24'h000001, 12'h002);
        fetch_instr("seq2", 12'h002, 24'h3ABCDE, 12'h003);
        fetch_instr("seq3", 12'h003, 24'h7FFFFF, 12'h004);

        // conditional branches
        pm[0]    = 24'h801020;   // JZE 0x020
        pm[12'h020] = 24'h803040; // JCY 0x040
        pm[12'h040] = 24'h802050; // JNE 0x050
        do_reset();
        run = 1'b1; z_flag = 1'b1; cy_flag = 1'b1;
        fetch_instr("jze_t", 12'h000, 24'h801020, 12'h020);
        fetch_instr("jcy_t", 12'h020, 24'h803040, 12'h040);
        fetch_instr("jne_nt", 12'h040, 24'h802050, 12'h041);
        do_reset();
        run = 1'b1; z_flag = 1'b0; cy_flag = 1'b0;
        fetch_instr("jze_nt", 12'h000, 24'h801020, 12'h001);

        // BSR / RET pair
        pm[0] = 24'h805100;
        pm[12'h100] = 24'h804000;
        do_reset();
        run = 1'b1;
        fetch_instr("bsr", 12'h000, 24'h805100, 12'h100);
        chk("bsr.sp", dut.u_stack.sp, 4'd1);
        fetch_instr("ret", 12'h100, 24'h804000, 12'h001);
        chk("ret.sp", dut.u_stack.sp, 4'd0);
        chk("ret.stack_err", stack_err, 1'b0);

        // nine nested BSRs, ninth overflows
        for (int i = 0; i < 9; i++) pm[i*16] = 24'h805000 | 24'((i+1)*16);
        pm[12'h090] = 24'h804000;
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 8; i++)
            fetch_instr("nest", 12'(i*16), 24'h805000 | 24'((i+1)*16), 12'((i+1)*16));
        chk("nest8.sp", dut.u_stack.sp, 4'd8);
        chk("nest8.stack_err", stack_err, 1'b0);
        fetch_instr("nest9", 12'h080, 24'h805090, 12'h090);
        chk("nest9.sp", dut.u_stack.sp, 4'd8);
        chk("nest9.stack_err", stack_err, 1'b1);
        fetch_instr("nest_ret", 12'h090, 24'h804000, 12'h071);
        chk("nest_ret.sp", dut.u_stack.sp, 4'd7);

        // RET on empty stack
        pm[0] = 24'h804000;
        do_reset();
        run = 1'b1;
        fetch_instr("ret_empty", 12'h000, 24'h804000, 12'h001);
        chk("ret_empty.stack_err", stack_err, 1'b1);

        // pc wrap, then run dropped mid-EXEC
        pm[0] = 24'h800FFF;   // JMP 0xFFF
        pm[12'hFFF] = 24'h000000;
        do_reset();
        run = 1'b1;
        fetch_instr("jmp", 12'h000, 24'h800FFF, 12'hFFF);
        fetch_instr("wrap", 12'hFFF, 24'h000000, 12'h000);
        #1;
        chk("stop.pm_addr", pm_addr, 12'h000);
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("stop.ir_valid", ir_valid, 1'b1);
        chk("stop.IR", IR, 24'h800FFF);
        @(negedge clk);
        #1;
        chk("idle.pm_rd", pm_rd, 1'b0);
        chk("idle.ir_valid", ir_valid, 1'b0);
        chk("idle.pc", pc, 12'hFFF);
        @(negedge clk);
        @(negedge clk);
        chk("idle2.pm_rd", pm_rd, 1'b0);
        chk("idle2.IR", IR, 24'h800FFF);
        chk("idle2.pc", pc, 12'hFFF);

        // reset during EXEC after a BSR
        pm[0] = 24'h805100;
        do_reset();
        run = 1'b1;
        #1;
        chk("rx.pm_rd", pm_rd, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("rx.pre_pc", pc, 12'h100);
        chk("rx.pre_sp", dut.u_stack.sp, 4'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rx.pc", pc, 12'h000);
        chk("rx.IR", IR, 24'h000000);
        chk("rx.ir_valid", ir_valid, 1'b0);
        chk("rx.sp", dut.u_stack.sp, 4'd0);
        chk("rx.stack_err", stack_err, 1'b0);
        rst_n = 1'b1;
        run = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
